// File: rtl/melody_pkg.sv
// Shared music-box constants: clock rate, note/period widths and the nominal
// tone period table used by both the tone generator and the note detector.
package melody_pkg;

    localparam int unsigned CLK_HZ    = 12000000;
    localparam int unsigned NOTE_W    = 3;
    localparam int unsigned PERIOD_W  = 17;
    localparam int unsigned NUM_NOTES = 8;

    // Packed so that NOTE_PERIOD[i] is the period of note i (0=Do .. 7=+Do).
    localparam logic [NUM_NOTES-1:0][PERIOD_W-1:0] NOTE_PERIOD = {
        17'd22933, 17'd24297, 17'd27273, 17'd30612,
        17'd34362, 17'd36404, 17'd40864, 17'd45866
    };

    typedef enum logic [1:0] {
        DET_IDLE  = 2'd0,
        DET_ARMED = 2'd1,
        DET_TRACK = 2'd2
    } det_state_t;

    // 18-bit signed difference keeps the sign of (meas - nom) for any 17-bit pair.
    function automatic logic within_tol(input logic [PERIOD_W-1:0] meas,
                                        input logic [PERIOD_W-1:0] nom,
                                        input logic [PERIOD_W:0]   tol);
        logic signed [PERIOD_W:0] diff;
        logic        [PERIOD_W:0] mag;
        diff = $signed({1'b0, meas}) - $signed({1'b0, nom});
        mag  = (diff < 0) ? $unsigned(-diff) : $unsigned(diff);
        return (mag <= tol);
    endfunction

endpackage

// File: rtl/note_detector_if.sv
// Tone input and decoded-note outputs of the note detector, bundled for the top port.
interface note_detector_if;
    import melody_pkg::*;

    logic                audio_in;
    logic [NOTE_W-1:0]   note;
    logic                note_valid;
    logic                note_change;
    logic [PERIOD_W-1:0] period;

    modport master (
        output audio_in,
        input  note,
        input  note_valid,
        input  note_change,
        input  period
    );

    modport slave (
        input  audio_in,
        output note,
        output note_valid,
        output note_change,
        output period
    );

endinterface

// File: rtl/note_detector_edge_sync.sv
// Two-flop synchroniser for the asynchronous tone line followed by a
// registered one-cycle rising-edge pulse.
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise
);

    logic s1;
    logic s2;
    logic s3;
    logic rise_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            s3     <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            s1     <= async_in;
            s2     <= s1;
            s3     <= s2;
            rise_q <= s2 & ~s3;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/note_detector.sv
// Measures the period of an incoming square-wave tone and decodes it to a
// note index, reporting only after several consecutive matching periods.
module note_detector
    import melody_pkg::*;
#(
    parameter int unsigned TOL          = 500,
    parameter int unsigned STABLE_COUNT = 3,
    parameter int unsigned TIMEOUT      = 60000,
    parameter logic [NUM_NOTES-1:0][PERIOD_W-1:0] NOMINAL = NOTE_PERIOD
) (
    input  logic            clk,
    input  logic            rst,
    note_detector_if.slave  bus
);

    localparam int unsigned         CNT_W     = $clog2(STABLE_COUNT + 1);
    localparam logic [PERIOD_W:0]   TOL_V     = (PERIOD_W + 1)'(TOL);
    localparam logic [PERIOD_W-1:0] TIMEOUT_V = PERIOD_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]    STABLE_V  = CNT_W'(STABLE_COUNT);

    logic                rise;
    det_state_t          state;
    logic [PERIOD_W-1:0] cnt;
    logic [NOTE_W-1:0]   cand;
    logic [CNT_W-1:0]    cand_cnt;

    logic [NOTE_W-1:0]   note_q;
    logic                note_valid_q;
    logic                note_change_q;
    logic [PERIOD_W-1:0] period_q;

    logic                hit;
    logic [NOTE_W-1:0]   hit_idx;
    logic [CNT_W-1:0]    cand_cnt_upd;
    logic                report;

    edge_sync u_edge_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (bus.audio_in),
        .rise     (rise)
    );

    // The running count equals the period being closed by this edge, so it is
    // classified directly; tolerance is under half the nominal gap, so at most one hit.
    always_comb begin
        hit          = 1'b0;
        hit_idx      = '0;
        cand_cnt_upd = '0;
        report       = 1'b0;
        for (int i = 0; i < int'(NUM_NOTES); i++) begin
            if (within_tol(cnt, NOMINAL[i], TOL_V)) begin
                hit     = 1'b1;
                hit_idx = NOTE_W'(i);
            end
        end
        if (hit_idx == cand) begin
            cand_cnt_upd = (cand_cnt == STABLE_V) ? cand_cnt : cand_cnt + 1'b1;
        end else begin
            cand_cnt_upd = CNT_W'(1);
        end
        report = (cand_cnt_upd == STABLE_V) && (!note_valid_q || (note_q != hit_idx));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= DET_IDLE;
            cnt           <= '0;
            cand          <= '0;
            cand_cnt      <= '0;
            note_q        <= '0;
            note_valid_q  <= 1'b0;
            note_change_q <= 1'b0;
            period_q      <= '0;
        end else begin
            note_change_q <= 1'b0;

            if (rise) begin
                cnt <= PERIOD_W'(1);
            end else if (cnt != TIMEOUT_V) begin
                cnt <= cnt + 1'b1;
            end

            unique case (state)
                DET_IDLE: begin
                    if (rise) begin
                        state <= DET_ARMED;
                    end
                end
                DET_ARMED, DET_TRACK: begin
                    if (rise) begin
                        state    <= DET_TRACK;
                        period_q <= cnt;
                        if (hit) begin
                            cand     <= hit_idx;
                            cand_cnt <= cand_cnt_upd;
                            if (report) begin
                                note_q        <= hit_idx;
                                note_valid_q  <= 1'b1;
                                note_change_q <= 1'b1;
                            end else if (note_valid_q && (hit_idx != note_q)) begin
                                // A different in-tolerance note means the reported tone is gone.
                                note_valid_q <= 1'b0;
                            end
                        end else begin
                            cand_cnt     <= '0;
                            note_valid_q <= 1'b0;
                        end
                    end else if (cnt == TIMEOUT_V) begin
                        state        <= DET_IDLE;
                        cand_cnt     <= '0;
                        note_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state <= DET_IDLE;
                end
            endcase
        end
    end

    assign bus.note        = note_q;
    assign bus.note_valid  = note_valid_q;
    assign bus.note_change = note_change_q;
    assign bus.period      = period_q;

endmodule

// File: tb/tb_note_detector.sv
// Scenario bench for note_detector, run with a scaled-down period table so every
// scenario fits a short simulation; note_change pulses are checked via a scoreboard.
module tb_note_detector;
    import melody_pkg::*;

    localparam int unsigned TB_TOL     = 6;
    localparam int unsigned TB_STABLE  = 3;
    localparam int unsigned TB_TIMEOUT = 700;
    localparam logic [NUM_NOTES-1:0][PERIOD_W-1:0] TB_NOMINAL = {
        17'd229, 17'd243, 17'd273, 17'd306, 17'd344, 17'd364, 17'd409, 17'd459
    };
    // Posedges from the negedge that raises audio_in to the posedge where the FSM registers it.
    localparam int DETECT_LAT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_rise = 0;
    logic [NOTE_W-1:0] exp_q[$];

    note_detector_if bus ();

    note_detector #(
        .TOL          (TB_TOL),
        .STABLE_COUNT (TB_STABLE),
        .TIMEOUT      (TB_TIMEOUT),
        .NOMINAL      (TB_NOMINAL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every note_change pulse must match the next expected note pushed by a scenario.
    always @(negedge clk) begin
        if (!rst && bus.note_change === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_change: note_change=1 note=%0d, required no pulse", bus.note);
            end else begin
                automatic logic [NOTE_W-1:0] exp_note = exp_q.pop_front();
                if (bus.note !== exp_note || bus.note_valid !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL change_note: note=%0d valid=%b, required note=%0d valid=1",
                             bus.note, bus.note_valid, exp_note);
                end
            end
        end
    end

    task automatic applyStimulus(input int per, input int n);
        for (int i = 0; i < n; i++) begin
            bus.audio_in = 1'b1;
            last_rise    = cyc;
            repeat (per / 2) @(negedge clk);
            bus.audio_in = 1'b0;
            repeat (per - per / 2) @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.audio_in = 1'b0;
        rst          = 1'b1;
        @(negedge clk);
        rst          = 1'b0;
    endtask

    task automatic expect_state(input string name, input logic valid, input logic [NOTE_W-1:0] nt,
                                input logic [PERIOD_W-1:0] per);
        checks++;
        if (bus.note_valid !== valid || bus.note !== nt || bus.period !== per) begin
            errors++;
            $display("[TB] FAIL %s: valid=%b note=%0d period=%0d, required valid=%b note=%0d period=%0d",
                     name, bus.note_valid, bus.note, bus.period, valid, nt, per);
        end
    endtask

    task automatic drain_check(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s_pending: %0d expected note_change pulses missing, required 0",
                     name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        bus.audio_in = 1'b0;
        rst          = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.note !== 3'd0 || bus.note_valid !== 1'b0 || bus.note_change !== 1'b0 || bus.period !== 17'd0) begin
            errors++;
            $display("[TB] FAIL reset_state: note=%0d valid=%b change=%b period=%0d, required all 0",
                     bus.note, bus.note_valid, bus.note_change, bus.period);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic_tone();
        do_reset();
        applyStimulus(273, 3);
        expect_state("basic_before_valid", 1'b0, 3'd0, 17'd273);
        exp_q.push_back(3'd5);
        applyStimulus(273, 1);
        expect_state("basic_valid", 1'b1, 3'd5, 17'd273);
        applyStimulus(273, 3);
        expect_state("basic_hold", 1'b1, 3'd5, 17'd273);
        drain_check("basic");
    endtask

    task automatic test_tolerance();
        do_reset();
        applyStimulus(279, 3);
        exp_q.push_back(3'd5);
        applyStimulus(279, 2);
        expect_state("tol_inside", 1'b1, 3'd5, 17'd279);
        drain_check("tol_inside");
        do_reset();
        applyStimulus(280, 6);
        expect_state("tol_outside", 1'b0, 3'd0, 17'd280);
    endtask

    task automatic test_note_switch();
        do_reset();
        exp_q.push_back(3'd0);
        applyStimulus(459, 4);
        expect_state("switch_first", 1'b1, 3'd0, 17'd459);
        applyStimulus(229, 1);
        expect_state("switch_last_long", 1'b1, 3'd0, 17'd459);
        applyStimulus(229, 1);
        expect_state("switch_drop", 1'b0, 3'd0, 17'd229);
        exp_q.push_back(3'd7);
        applyStimulus(229, 2);
        expect_state("switch_second", 1'b1, 3'd7, 17'd229);
        applyStimulus(229, 1);
        drain_check("switch");
    endtask

    task automatic test_tone_loss();
        int waited;
        do_reset();
        exp_q.push_back(3'd3);
        applyStimulus(344, 5);
        expect_state("loss_before", 1'b1, 3'd3, 17'd344);
        waited = 0;
        while (bus.note_valid === 1'b1 && waited < int'(TB_TIMEOUT) + 100) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (bus.note_valid !== 1'b0 || (cyc - last_rise) != int'(TB_TIMEOUT) + DETECT_LAT) begin
            errors++;
            $display("[TB] FAIL loss_timing: valid=%b fell %0d cycles after rise, required 0 after %0d",
                     bus.note_valid, cyc - last_rise, int'(TB_TIMEOUT) + DETECT_LAT);
        end
        expect_state("loss_hold_note", 1'b0, 3'd3, 17'd344);
        applyStimulus(344, 1);
        expect_state("loss_rearm_only", 1'b0, 3'd3, 17'd344);
        drain_check("loss");
    endtask

    task automatic test_glitch();
        do_reset();
        exp_q.push_back(3'd2);
        applyStimulus(364, 4);
        expect_state("glitch_before", 1'b1, 3'd2, 17'd364);
        applyStimulus(10, 1);
        applyStimulus(364, 1);
        expect_state("glitch_drop", 1'b0, 3'd2, 17'd10);
        applyStimulus(364, 2);
        expect_state("glitch_recovering", 1'b0, 3'd2, 17'd364);
        exp_q.push_back(3'd2);
        applyStimulus(364, 1);
        expect_state("glitch_recovered", 1'b1, 3'd2, 17'd364);
        drain_check("glitch");
    endtask

    task automatic test_reset_mid();
        do_reset();
        exp_q.push_back(3'd4);
        applyStimulus(306, 4);
        expect_state("rstmid_before", 1'b1, 3'd4, 17'd306);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.note !== 3'd0 || bus.note_valid !== 1'b0 || bus.note_change !== 1'b0 || bus.period !== 17'd0) begin
            errors++;
            $display("[TB] FAIL rstmid_clear: note=%0d valid=%b change=%b period=%0d, required all 0",
                     bus.note, bus.note_valid, bus.note_change, bus.period);
        end
        applyStimulus(306, 3);
        expect_state("rstmid_three_edges", 1'b0, 3'd0, 17'd306);
        exp_q.push_back(3'd4);
        applyStimulus(306, 1);
        expect_state("rstmid_reacquired", 1'b1, 3'd4, 17'd306);
        drain_check("rstmid");
    endtask

    initial begin
        $display("[TB] note_detector bench start");
        test_reset();
        test_basic_tone();
        test_tolerance();
        test_note_switch();
        test_tone_loss();
        test_glitch();
        test_reset_mid();
        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
